// File: rtl/serial_to_parallel.sv
// Deserializer: packs DATA_W serial bits into a word held in a
// one-entry valid/ready output register with a sticky overrun flag.
module serial_to_parallel #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              serial_valid,
  input  logic              sync,
  output logic [DATA_W-1:0] parallel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     bit_cnt,
  output logic              overrun,
  input  logic              clr_ovr
);

  typedef enum logic {IDLE, RECV} state_e;

  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] shifted;
  logic              last;
  logic              ovr_set;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    ovr_set = 1'b0;

    // A fresh word (idle or resync) starts from an empty register.
    base = (state_q == RECV && !sync) ? shift_q : '0;
    if (MSB_FIRST) begin
      shifted = {base[DATA_W-2:0], serial_in};
    end else begin
      shifted = {serial_in, base[DATA_W-1:1]};
    end

    last = serial_valid && !sync && (cnt_q == LAST);

    if (serial_valid) begin
      shift_d = shifted;
      cnt_d   = sync ? CW'(1) : cnt_q + CW'(1);
      state_d = RECV;
    end else if (sync) begin
      shift_d = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end

    if (last) begin
      shift_d = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end

    if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end

    if (last) begin
      if (!vld_q || out_ready) begin
        out_d = shifted;
        vld_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    // Set wins over clear.
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = out_q;
  assign out_valid    = vld_q;
  assign bit_cnt      = cnt_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: vector table, directed corner
// sequences and random traffic against a queue-based word model.
module tb_serial_to_parallel;

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic       serial_valid;
  logic       sync;
  logic       out_ready;
  logic       clr_ovr;

  logic [7:0] po_m, po_l;
  logic       vld_m, vld_l;
  logic [3:0] cnt_m, cnt_l;
  logic       ovr_m, ovr_l;

  serial_to_parallel #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .sync         (sync),
    .parallel_out (po_m),
    .out_valid    (vld_m),
    .out_ready    (out_ready),
    .bit_cnt      (cnt_m),
    .overrun      (ovr_m),
    .clr_ovr      (clr_ovr)
  );

  serial_to_parallel #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .sync         (sync),
    .parallel_out (po_l),
    .out_valid    (vld_l),
    .out_ready    (out_ready),
    .bit_cnt      (cnt_l),
    .overrun      (ovr_l),
    .clr_ovr      (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: bits of the partial word, plus the output register.
  bit       mq[$];
  bit       m_vld = 0;
  bit [7:0] m_out_m = 0;
  bit [7:0] m_out_l = 0;
  bit       m_ovr = 0;

  typedef struct {
    logic       sv, si, sy, rdy, clr;
    logic       vld;
    logic [7:0] out;
    logic [3:0] cnt;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, sv, si, sy, rdy, clr);
    bit       done;
    bit       pend;
    bit [7:0] wm, wl;
    done = 0;
    wm = 0;
    wl = 0;
    if (!r) begin
      mq.delete();
      m_vld = 0;
      m_out_m = 0;
      m_out_l = 0;
      m_ovr = 0;
      return;
    end
    if (sy) begin
      mq.delete();
      if (sv) mq.push_back(si);
    end else if (sv) begin
      mq.push_back(si);
      if (mq.size() == 8) begin
        done = 1;
        foreach (mq[i]) begin
          wm = {wm[6:0], mq[i]};
          wl[i] = mq[i];
        end
        mq.delete();
      end
    end
    pend = m_vld;
    if (pend && rdy) m_vld = 0;
    if (clr) m_ovr = 0;
    if (done) begin
      if (!pend || rdy) begin
        m_out_m = wm;
        m_out_l = wl;
        m_vld = 1;
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  task automatic cyc(input logic r, sv, si, sy, rdy, clr);
    rst_n = r;
    serial_valid = sv;
    serial_in = si;
    sync = sy;
    out_ready = rdy;
    clr_ovr = clr;
    model_step(r, sv, si, sy, rdy, clr);
    @(posedge clk);
    @(negedge clk);
    chk("m_valid", vld_m, m_vld);
    chk("m_out", po_m, m_out_m);
    chk("m_cnt", cnt_m, mq.size());
    chk("m_ovr", ovr_m, m_ovr);
    chk("l_valid", vld_l, m_vld);
    chk("l_out", po_l, m_out_l);
    chk("l_cnt", cnt_l, mq.size());
    chk("l_ovr", ovr_l, m_ovr);
  endtask

  task automatic send(input logic [7:0] w, input logic rdy);
    for (int k = 0; k < 8; k++) cyc(1, 1, w[7-k], 0, rdy, 0);
  endtask

  task automatic add_row(input logic sv, si, rdy, clr, vld,
                         input logic [7:0] out,
                         input logic [3:0] cnt, input logic ovr);
    vec_t v;
    v.sv = sv; v.si = si; v.sy = 0; v.rdy = rdy; v.clr = clr;
    v.vld = vld; v.out = out; v.cnt = cnt; v.ovr = ovr;
    tbl.push_back(v);
  endtask

  task automatic add_word(input logic [7:0] w,
                          input logic rdy_mid, rdy_end,
                          input logic vld_mid,
                          input logic [7:0] out_mid,
                          input logic ovr_mid, vld_end,
                          input logic [7:0] out_end,
                          input logic ovr_end, clr_end);
    for (int k = 0; k < 7; k++)
      add_row(1, w[7-k], rdy_mid, 0, vld_mid, out_mid,
              4'(k + 1), ovr_mid);
    add_row(1, w[0], rdy_end, clr_end, vld_end, out_end, 4'd0, ovr_end);
  endtask

  initial begin
    rst_n = 0;
    serial_in = 0;
    serial_valid = 0;
    sync = 0;
    out_ready = 0;
    clr_ovr = 0;

    // Reset with serial_valid toggling
    for (int i = 0; i < 3; i++) cyc(0, i[0], 1, 0, 0, 0);
    chk("rst_valid", vld_m, 0);
    chk("rst_cnt", cnt_m, 0);
    chk("rst_out", po_m, 0);
    chk("rst_ovr", ovr_m, 0);

    // Table: A5 back-to-back; 3C/07 overrun + clr; 03/04 consume+load;
    // 11/22 overrun coinciding with clr (set wins).
    add_word(8'hA5, 1, 1, 0, 8'h00, 0, 1, 8'hA5, 0, 0);
    add_row(0, 0, 1, 0, 0, 8'hA5, 0, 0);
    add_word(8'h3C, 0, 0, 0, 8'hA5, 0, 1, 8'h3C, 0, 0);
    add_word(8'h07, 0, 0, 1, 8'h3C, 0, 1, 8'h3C, 1, 0);
    add_row(0, 0, 0, 1, 1, 8'h3C, 0, 0);
    add_row(0, 0, 1, 0, 0, 8'h3C, 0, 0);
    add_word(8'h03, 0, 0, 0, 8'h3C, 0, 1, 8'h03, 0, 0);
    add_word(8'h04, 0, 1, 1, 8'h03, 0, 1, 8'h04, 0, 0);
    add_row(0, 0, 1, 0, 0, 8'h04, 0, 0);
    add_word(8'h11, 0, 0, 0, 8'h04, 0, 1, 8'h11, 0, 0);
    add_word(8'h22, 0, 0, 1, 8'h11, 0, 1, 8'h11, 1, 1);
    add_row(0, 0, 1, 1, 0, 8'h11, 0, 0);

    foreach (tbl[i]) begin
      cyc(1, tbl[i].sv, tbl[i].si, 0, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), vld_m, tbl[i].vld);
      chk($sformatf("tbl%0d_out", i), po_m, tbl[i].out);
      chk($sformatf("tbl%0d_cnt", i), cnt_m, tbl[i].cnt);
      chk($sformatf("tbl%0d_ovr", i), ovr_m, tbl[i].ovr);
    end

    // A5 with 1..3-cycle gaps; count must hold through gaps
    begin
      logic [7:0] w;
      w = 8'hA5;
      for (int k = 0; k < 8; k++) begin
        cyc(1, 1, w[7-k], 0, 1, 0);
        if (k < 7) begin
          for (int g = 0; g <= k % 3; g++) begin
            cyc(1, 0, ~w[7-k], 0, 1, 0);
            chk("gap_cnt", cnt_m, k + 1);
            chk("gap_valid", vld_m, 0);
          end
        end
      end
      chk("gap_out", po_m, 8'hA5);
      chk("gap_valid_end", vld_m, 1);
      cyc(1, 0, 0, 0, 1, 0);
    end

    // Partial word then reset: no residue
    for (int k = 0; k < 5; k++) cyc(1, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 1, 0);
    chk("rst_mid_cnt", cnt_m, 0);
    send(8'h05, 1);
    chk("rst5_out_m", po_m, 8'h05);
    chk("rst5_out_l", po_l, 8'hA0);
    chk("rst5_valid", vld_m, 1);
    cyc(1, 0, 0, 0, 1, 0);

    // Partial word then sync without a bit: no residue
    for (int k = 0; k < 5; k++) cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 0, 1, 1, 1, 0);
    chk("sync_cnt", cnt_m, 0);
    send(8'h80, 1);
    chk("sync_out_m", po_m, 8'h80);
    chk("sync_out_l", po_l, 8'h01);
    cyc(1, 0, 0, 0, 1, 0);

    // sync on the 8th bit: partial discarded, new word starts
    for (int k = 0; k < 7; k++) cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 1, 1, 0);
    chk("sync8_cnt", cnt_m, 1);
    chk("sync8_valid", vld_m, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 199) != 0),
          logic'($urandom_range(0, 9) < 7),
          logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 39) == 0),
          logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
